// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares one physical-memory line port between the I-cache and the D-cache.
// One transaction is granted at a time. The grant is normally given to the
// D-cache, but the I-cache is guaranteed service after STARVE_LIMIT
// consecutive D grants taken while it was waiting. Request, address and
// write data are not latched: each requester must hold them until its resp.
module cache_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    logic [2:0] streak;
    logic       d_req;

    assign d_req = d_read | d_write;

    // Read data goes straight through; it is meaningful only in a resp cycle.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Arbitration FSM and D-over-I streak counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            streak <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && i_read) begin
                        if (streak == LIMIT) begin
                            // I has waited through LIMIT D grants: its turn.
                            state  <= SERVE_I;
                            streak <= 3'd0;
                        end else begin
                            state  <= SERVE_D;
                            streak <= (streak >= LIMIT) ? LIMIT : streak + 3'd1;
                        end
                    end else if (i_read) begin
                        state  <= SERVE_I;
                        streak <= 3'd0;
                    end else if (d_req) begin
                        state  <= SERVE_D;
                        streak <= 3'd0;
                    end else begin
                        streak <= 3'd0;
                    end
                end
                SERVE_I: if (mem_resp) state <= DONE;
                SERVE_D: if (mem_resp) state <= DONE;
                // One-cycle bubble so the served cache can drop its request.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side strobes and cache responses decoded from the grant state.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state)
            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
                i_resp      = mem_resp;
            end
            SERVE_D: begin
                // A write-back wins over a fill if both are requested.
                mem_write   = d_write;
                mem_read    = d_read & ~d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                d_resp      = mem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory line port between the instruction cache and the data cache of the pipelined RV32I core. Accepts line-fill reads from the I-cache and line reads/write-backs from the D-cache, and grants one at a time. Forwards each granted transaction to memory and returns the memory response to the granted cache only. Sits between the two L1 caches and the cacheline adaptor/physical memory.

## Interface
Parameters:
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, line address width
- STARVE_LIMIT, 4, max consecutive D grants while I is waiting (1..7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- i_read  in  1  I-cache line-fill request
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line data to I-cache
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line-fill request
- d_write  in  1  D-cache write-back request
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache write-back data
- d_rdata  out  LINE_WIDTH  line data to D-cache
- d_resp  out  1  D-cache transaction complete
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  memory line address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data
- mem_resp  in  1  memory transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE. Reset state IDLE; streak counter = 0.
- IDLE: evaluates requests each cycle. If d_read|d_write and i_read are both high, go to SERVE_D, unless streak == STARVE_LIMIT, in which case go to SERVE_I. A lone request goes to its SERVE state. With no request, stay in IDLE.
- Streak counter (3-bit): +1 on each IDLE->SERVE_D transition taken while i_read is high. Cleared on IDLE->SERVE_I, and cleared in IDLE whenever i_read is low. It saturates at STARVE_LIMIT.
- SERVE_I: mem_read=1, mem_address=i_address, mem_write=0.
- SERVE_D: mem_address=d_address. mem_write=d_write and mem_wdata=d_wdata. mem_read=d_read & ~d_write; write wins if both are high.
- In SERVE_x, mem strobes and address are held constant until mem_resp. When mem_resp arrives: assert x_resp combinationally in that same cycle, then go to DONE.
- DONE: exactly one cycle. All strobes and resps are 0. Then go to IDLE. This bubble lets the cache drop its request before re-arbitration.
- i_rdata and d_rdata are wired directly to mem_rdata. They are valid only in the x_resp cycle.
- Outside SERVE states, mem_read, mem_write, i_resp and d_resp are all 0. mem_address and mem_wdata are 0 in IDLE/DONE.
- Requesters must hold request, address and wdata stable until their resp. The arbiter does not latch them.
- mem_resp received in IDLE or DONE is ignored.

## Timing
- Reset values: all outputs 0 except i_rdata and d_rdata, which follow mem_rdata. State IDLE, streak 0.
- Asserting rst mid-transaction immediately drops the strobes and returns to IDLE. The memory model is reset with it.
- Grant latency: a request sampled high in IDLE at edge N drives mem strobes from edge N (after the edge, state = SERVE_x).
- Response latency is 0 cycles: x_resp = mem_resp & (state==SERVE_x).
- Minimum back-to-back turnaround is resp cycle, then DONE, then IDLE, then SERVE. The next grant's strobes appear 3 edges after the resp edge.
- A request that drops in IDLE before being sampled is never issued.
- There is never a cycle with mem_read and mem_write both high. There is never a cycle with i_resp and d_resp both high.

## Test plan
- I-only read, memory latency 5: i_read=1, i_address=0x0000_1000 -> mem_read=1, mem_address=0x1000 for 5 cycles. i_resp pulses 1 cycle with i_rdata=mem_rdata. Then DONE, then IDLE. d_resp stays 0 throughout.
- Simultaneous i_read and d_write (d_address=0x2000, d_wdata=0xA5…A5) -> D is granted first: mem_write=1, mem_wdata=0xA5…A5. After d_resp and DONE, I is granted next.
- Starvation: d_read held continuously plus i_read held, STARVE_LIMIT=4 -> exactly 4 D grants, then an I grant. The streak is 0 afterward.
- d_read and d_write both high -> only mem_write asserted. Assertion: mem_read & mem_write never true for the whole run.
- Reset mid-SERVE_D (2 cycles into latency) -> mem_write drops asynchronously and the state is IDLE. After rst falls with i_read high, SERVE_I is entered on the next edge.
- Spurious mem_resp in IDLE -> i_resp and d_resp stay 0 and there is no state change.
